snake_game_ctrl: RTL and testbench
==================================

Name: snake_game_ctrl

Overview:
- Central sequencer for the snake game, running in the video_clk domain.
- Owns the game state machine (idle / play / pause / over) and the direction register, including the reversal-lock rule.
- Generates the movement step strobe from the VGA frame tick, with speed scaling by score.
- Runs the apple respawn request/acknowledge handshake with the box generator and keeps the score.

Parameters:
- BASE_PERIOD, 12, frames per snake step at level 0.
- MIN_PERIOD, 3, floor on frames per step; level scaling never goes below this.
- LEVEL_APPLES, 4, apples eaten per speed level; each level reduces the period by 1 frame.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  video clock, the same domain as the VGA driver.
- rst  in  1  reset, synchronous, active-high.
- key_start  in  1  start key, active-low level, already debounced.
- key_u  in  1  up key, active-low level.
- key_d  in  1  down key, active-low level.
- key_l  in  1  left key, active-low level.
- key_r  in  1  right key, active-low level.
- frame_tick  in  1  one-cycle pulse per VGA frame, at start of vertical sync.
- hit_apple  in  1  snake head on apple; sampled only in the cycle after step.
- hit_wall  in  1  head left the playfield; sampled only in the cycle after step.
- hit_self  in  1  head overlaps the body; sampled only in the cycle after step.
- apple_ack  in  1  box generator has loaded new apple coordinates.
- state  out  2  game state: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER.
- step  out  1  one-cycle pulse; the snake advances one cell.
- dir  out  2  current direction: 0 right, 1 left, 2 up, 3 down.
- grow  out  1  one-cycle pulse, coincident with the apple_req rise; snake lengthens.
- apple_req  out  1  level request for new apple placement.
- score  out  SCORE_W  apples eaten; saturates at all-ones.
- level  out  4  current speed level.

Behaviour:
- Key handling: all key inputs are registered once. A press is the 1->0 edge, i.e. prev=1 and now=0, giving a one-cycle press event.
- Reset values: state=IDLE, step=0, dir=0 (right), grow=0, apple_req=0, score=0, level=0; frame counter=0; pending direction=right. Every register (prev-key, pending direction, frame counter, apple-eaten counter, apple_req) also resets, so a rst asserted mid-game or mid-handshake is taken on the next clk edge with nothing left over.
- IDLE:
  - start press -> PLAY.
  - Entering PLAY clears score, level, frame counter and the apple-eaten counter, sets dir=right, and asserts apple_req to place the first apple.
- PLAY, direction:
  - A direction press loads the pending direction, unless it is the exact opposite of the current dir (R<->L, U<->D), in which case it is ignored.
  - If several direction presses occur in the same cycle, priority is u > d > l > r.
  - The latest accepted press before a step wins.
  - dir takes the pending value in the same cycle that step pulses.
- PLAY, stepping:
  - The frame counter increments on each frame_tick.
  - When counter+1 == period, step pulses for one cycle and the counter clears.
  - period = max(BASE_PERIOD - level, MIN_PERIOD), computed with unsigned arithmetic that is clamped so it never underflows.
- PLAY, collision (checked in the cycle after step):
  - hit_wall or hit_self -> OVER. This takes priority over hit_apple in the same cycle.
  - Otherwise hit_apple:
    - score += 1, saturating at all-ones.
    - grow pulses.
    - apple_req goes to 1.
    - The apple-eaten counter increments. When it reaches LEVEL_APPLES it clears and level += 1, saturating at 15.
- Apple handshake:
  - apple_req stays high until a cycle where apple_ack=1; it clears in the cycle after that ack.
  - While apple_req is high, a further hit_apple does not score, does not pulse grow, and does not re-request.
  - apple_ack while apple_req=0 is ignored.
- OVER:
  - step is frozen; score and level are held.
  - start press -> IDLE.
- State priority: a start press in the same cycle as a collision is ignored; the collision result wins.
- Latency: key press to pending direction is 2 cycles. The frame_tick that completes a period produces step in the next cycle.

Optional Feature:
- Macro: SNAKE_PAUSE_EN.
- When defined:
  - A start press in PLAY -> PAUSE.
  - In PAUSE: no step; frame_tick is ignored; the frame counter is held; direction presses are ignored.
  - A start press in PAUSE -> PLAY with the counter resumed, not cleared.
  - apple_req/ack still complete while in PAUSE.
- When undefined:
  - A start press in PLAY is ignored.
  - State 2 is unreachable; if forced, it returns to IDLE the next cycle.

Test Plan:
1. rst high for 3 cycles, release, start press -> state=1, apple_req=1 and held until apple_ack pulses, then 0 the next cycle; dir=0, score=0.
2. PLAY at level 0, 24 frame_ticks -> exactly 2 step pulses, each on the cycle after the 12th and 24th tick.
3. dir=right, press key_l -> dir stays 0. Press key_u then key_d between the same two steps -> dir=3 at the next step.
4. Pulse hit_apple 4 times after steps, with ack each time -> score=4, level=1, and the next step interval is 11 frames. Repeat until level reaches BASE_PERIOD-MIN_PERIOD -> period stays at 3.
5. hit_apple and hit_wall in the same cycle -> state=3, score unchanged, no grow. Start press -> state=0.
6. SNAKE_PAUSE_EN: start press in PLAY after 5 ticks -> state=2; 20 ticks produce no step. Start press -> step after 7 more ticks. Rst asserted in PAUSE -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, direction register with reversal lock, frame-based step strobe, apple handshake, score/level.
// Optional macro SNAKE_PAUSE_EN adds a PAUSE state entered/left with the start key.
module snake_game_ctrl #(
  parameter int BASE_PERIOD  = 12,
  parameter int MIN_PERIOD   = 3,
  parameter int LEVEL_APPLES = 4,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start,
  input  logic               key_u,
  input  logic               key_d,
  input  logic               key_l,
  input  logic               key_r,
  input  logic               frame_tick,
  input  logic               hit_apple,
  input  logic               hit_wall,
  input  logic               hit_self,
  input  logic               apple_ack,
  output logic [1:0]         state,
  output logic               step,
  output logic [1:0]         dir,
  output logic               grow,
  output logic               apple_req,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level
);

  localparam int CW = $clog2(BASE_PERIOD + 1);
  localparam int EW = (LEVEL_APPLES > 1) ? $clog2(LEVEL_APPLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t          cur, nxt;
  logic [4:0]      key_now, key_prev, press;
  logic [1:0]      pend, dir_new;
  logic            dir_vld, dir_take;
  logic            chk, collide, start_game, run, eat;
  logic [CW-1:0]   cnt, period;
  logic [EW-1:0]   eaten;

  // Key vector order: {start, up, down, left, right}; keys are active-low.
  assign press      = key_prev & ~key_now;
  assign state      = cur;
  assign collide    = chk && (cur == PLAY) && (hit_wall || hit_self);
  assign start_game = (cur == IDLE) && press[4];
  assign run        = (cur == PLAY) && (nxt == PLAY);
  assign eat        = chk && (cur == PLAY) && !hit_wall && !hit_self && hit_apple && !apple_req;

  always_comb begin
    period = CW'(MIN_PERIOD);
    if (int'(level) < BASE_PERIOD - MIN_PERIOD) period = CW'(BASE_PERIOD - int'(level));
  end

  // Direction codes are paired so that the opposite direction is dir ^ 1.
  always_comb begin
    dir_new = 2'd0;
    dir_vld = |press[3:0];
    if (press[3])      dir_new = 2'd2;
    else if (press[2]) dir_new = 2'd3;
    else if (press[1]) dir_new = 2'd1;
    dir_take = dir_vld && (cur == PLAY) && (dir_new != (dir ^ 2'b01));
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: if (press[4]) nxt = PLAY;
      PLAY: begin
        if (collide) nxt = OVER;
`ifdef SNAKE_PAUSE_EN
        else if (press[4]) nxt = PAUSE;
`endif
      end
`ifdef SNAKE_PAUSE_EN
      PAUSE: if (press[4]) nxt = PLAY;
`else
      PAUSE: nxt = IDLE;
`endif
      OVER: if (press[4]) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= IDLE;
      key_now   <= 5'b11111;
      key_prev  <= 5'b11111;
      step      <= 1'b0;
      chk       <= 1'b0;
      dir       <= 2'd0;
      pend      <= 2'd0;
      grow      <= 1'b0;
      apple_req <= 1'b0;
      score     <= '0;
      level     <= 4'd0;
      cnt       <= '0;
      eaten     <= '0;
    end else begin
      cur      <= nxt;
      key_now  <= {key_start, key_u, key_d, key_l, key_r};
      key_prev <= key_now;
      step     <= 1'b0;
      grow     <= 1'b0;
      chk      <= step;
      if (apple_req && apple_ack) apple_req <= 1'b0;
      if (start_game) begin
        score     <= '0;
        level     <= 4'd0;
        cnt       <= '0;
        eaten     <= '0;
        dir       <= 2'd0;
        pend      <= 2'd0;
        apple_req <= 1'b1;
      end else begin
        if (dir_take) pend <= dir_new;
        // >= rather than == so a level-up mid-period cannot overrun the shorter period.
        if (run && frame_tick) begin
          if (cnt + CW'(1) >= period) begin
            step <= 1'b1;
            dir  <= pend;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        if (eat) begin
          if (score != '1) score <= score + SCORE_W'(1);
          grow      <= 1'b1;
          apple_req <= 1'b1;
          if (eaten == EW'(LEVEL_APPLES - 1)) begin
            eaten <= '0;
            if (level != 4'd15) level <= level + 4'd1;
          end else begin
            eaten <= eaten + EW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomized directed bench for snake_game_ctrl against an event-level game model.
module tb_snake_game_ctrl;
  localparam int BASE = 12, MINP = 3, LA = 4, SW = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic key_start = 1'b1, key_u = 1'b1, key_d = 1'b1, key_l = 1'b1, key_r = 1'b1;
  logic frame_tick = 1'b0, hit_apple = 1'b0, hit_wall = 1'b0, hit_self = 1'b0, apple_ack = 1'b0;
  logic [1:0] state, dir;
  logic step, grow, apple_req;
  logic [SW-1:0] score;
  logic [3:0] level;

  snake_game_ctrl #(.BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .LEVEL_APPLES(LA), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_u(key_u), .key_d(key_d),
    .key_l(key_l), .key_r(key_r), .frame_tick(frame_tick), .hit_apple(hit_apple),
    .hit_wall(hit_wall), .hit_self(hit_self), .apple_ack(apple_ack), .state(state),
    .step(step), .dir(dir), .grow(grow), .apple_req(apple_req), .score(score), .level(level)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int step_cnt = 0;
  always @(negedge clk) if (step === 1'b1) step_cnt++;

  // Game model: state, direction, scoring and frames since the last step.
  int m_state = 0, m_dir = 0, m_pend = 0, m_score = 0, m_level = 0, m_eaten = 0, m_ticks = 0;
  bit m_req = 0;

  function automatic int period_of(int lvl);
    return (BASE - lvl < MINP) ? MINP : BASE - lvl;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset();
    m_state = 0; m_dir = 0; m_pend = 0; m_score = 0; m_level = 0; m_eaten = 0; m_ticks = 0; m_req = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".dir"}, 32'(dir), 32'(m_dir));
    chk({tag, ".apple_req"}, 32'(apple_req), 32'(m_req));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".level"}, 32'(level), 32'(m_level));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".step"}, 32'(step), 0);
    chk({tag, ".grow"}, 32'(grow), 0);
    check_outputs(tag);
  endtask

  // k: 0 right, 1 left, 2 up, 3 down (same as direction code), 4 start
  task automatic press(input int k);
    case (k)
      0: key_r = 1'b0;
      1: key_l = 1'b0;
      2: key_u = 1'b0;
      3: key_d = 1'b0;
      default: key_start = 1'b0;
    endcase
    cyc(3);
    key_r = 1'b1; key_l = 1'b1; key_u = 1'b1; key_d = 1'b1; key_start = 1'b1;
    cyc(2);
    if (k < 4) begin
      if (m_state == 1 && k != (m_dir ^ 1)) m_pend = k;
    end else begin
      case (m_state)
        0: begin
          m_state = 1; m_score = 0; m_level = 0; m_eaten = 0; m_ticks = 0;
          m_dir = 0; m_pend = 0; m_req = 1;
        end
`ifdef SNAKE_PAUSE_EN
        1: m_state = 2;
        2: m_state = 1;
`endif
        3: m_state = 0;
        default: ;
      endcase
    end
  endtask

  task automatic frame(output bit got);
    bit exp = 0;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    if (m_state == 1) begin
      m_ticks++;
      if (m_ticks >= period_of(m_level)) begin
        exp = 1; m_ticks = 0; m_dir = m_pend;
      end
    end
    chk("step", 32'(step), 32'(exp));
    chk("dir_at_frame", 32'(dir), 32'(m_dir));
    got = step;
  endtask

  task automatic frames(input int n);
    bit g;
    repeat (n) begin frame(g); cyc($urandom_range(1, 3)); end
  endtask

  task automatic run_to_step();
    bit got = 0;
    int n = 0;
    while (!got && n < 20) begin
      cyc($urandom_range(0, 2));
      frame(got);
      n++;
    end
    chk("step_within_bound", 32'(got), 1);
  endtask

  task automatic hit(input bit apple, input bit wall, input bit self_hit);
    bit eg = 0;
    run_to_step();
    cyc(1);
    hit_apple = apple; hit_wall = wall; hit_self = self_hit;
    cyc(1);
    hit_apple = 1'b0; hit_wall = 1'b0; hit_self = 1'b0;
    if (wall || self_hit) m_state = 3;
    else if (apple && !m_req) begin
      if (m_score < 255) m_score++;
      m_eaten++;
      if (m_eaten == LA) begin
        m_eaten = 0;
        if (m_level < 15) m_level++;
      end
      m_req = 1; eg = 1;
    end
    chk("grow", 32'(grow), 32'(eg));
    check_outputs("hit");
  endtask

  task automatic ack();
    cyc($urandom_range(0, 3));
    chk("req_before_ack", 32'(apple_req), 32'(m_req));
    apple_ack = 1'b1;
    cyc(1);
    apple_ack = 1'b0;
    m_req = 0;
    chk("req_after_ack", 32'(apple_req), 0);
  endtask

  initial begin
    int s0;
    bit g;
    cyc(3);
    check_reset("reset");
    rst = 1'b0;
    cyc(2);

    // Start, first apple handshake held until ack.
    press(4);
    check_outputs("start");
    cyc($urandom_range(2, 6));
    chk("req_held", 32'(apple_req), 1);
    ack();
    apple_ack = 1'b1; cyc(1); apple_ack = 1'b0;
    chk("stray_ack", 32'(apple_req), 0);

    // 24 frames at level 0 -> two steps on the 12th and 24th tick.
    s0 = step_cnt;
    frames(24);
    chk("steps_in_24", 32'(step_cnt - s0), 2);

    // Reversal lock, then up/down between the same pair of steps.
    press(1);
    run_to_step();
    chk("dir_lock", 32'(dir), 0);
    press(2);
    press(3);
    run_to_step();
    chk("dir_down", 32'(dir), 3);
    for (int i = 0; i < 6; i++) begin
      press($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) press($urandom_range(0, 3));
      run_to_step();
    end

    // Hit outside the post-step cycle is ignored.
    cyc(2); hit_apple = 1'b1; cyc(1); hit_apple = 1'b0;
    check_outputs("stray_hit");

    // Apples and level scaling.
    for (int i = 0; i < 4; i++) begin hit(1, 0, 0); ack(); end
    chk("score4", 32'(score), 4);
    chk("level1", 32'(level), 1);
    hit(1, 0, 0);
    hit(1, 0, 0);
    ack();
    for (int i = 0; i < 36; i++) begin hit(1, 0, 0); ack(); end
    chk("level_hi", 32'(level), 10);
    s0 = step_cnt;
    frames(9);
    chk("floor_period", 32'(step_cnt - s0), 3);

    // Apple plus wall in the same cycle -> OVER, no score.
    hit(1, 1, 0);
    chk("over", 32'(state), 3);
    s0 = step_cnt;
    frames(15);
    chk("over_frozen", 32'(step_cnt - s0), 0);
    press(4);
    chk("over_to_idle", 32'(state), 0);

    // New game, self collision.
    press(4);
    check_outputs("restart");
    ack();
    hit(0, 0, 1);
    press(4);
    press(4);

`ifdef SNAKE_PAUSE_EN
    ack();
    run_to_step();
    frames(5);
    press(4);
    chk("paused", 32'(state), 2);
    s0 = step_cnt;
    frames(20);
    press(1);
    chk("pause_nostep", 32'(step_cnt - s0), 0);
    press(4);
    chk("resumed", 32'(state), 1);
    for (int i = 0; i < 7; i++) begin frame(g); cyc(1); end
    chk("resume_step", 32'(g), 1);
    press(4);
`else
    press(4);
    chk("no_pause", 32'(state), 1);
`endif

    // Reset mid-game with a request outstanding.
    hit(1, 0, 0);
    rst = 1'b1;
    cyc(1);
    model_reset();
    check_reset("mid_reset");
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
